// File: rtl/led_pkg.sv
// Shared sizes, mean-array types, FSM state encoding and mean helper for led_zone_mean.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package led_pkg;

  localparam int ZONE_NUM   = 16;
  localparam int MEAN_W     = 4;
  localparam int PIX_W      = 8;
  localparam int ZONE_COLS  = 4;
  localparam int ZONE_BANDS = 4;

  // Published mean set: one 4-bit mean per zone, zone = band*4 + column.
  typedef logic [MEAN_W-1:0] mean_arr_t [ZONE_NUM];

  // Means of the four zones of the band currently being accumulated.
  typedef logic [MEAN_W-1:0] band_mean_t [ZONE_COLS];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_BAND = 2'd2,
    ST_PUB  = 2'd3
  } zm_state_e;

  // Zone mean from a zone sum: divide by the zone area (shift), keep the top
  // nibble of the 8-bit average. With rounding, half an output LSB is added
  // first and a carry out of the 8-bit average saturates the mean at 4'hF.
  function automatic logic [MEAN_W-1:0] zone_mean(
    input logic [31:0] sum,
    input int          shift,
    input logic        round
  );
    logic [32:0] biased;
    logic [32:0] scaled;
    biased = {1'b0, sum};
    if (round) begin
      biased = biased + (33'd1 << (shift + 3));
    end
    scaled = biased >> shift;
    if (scaled > 33'd255) begin
      zone_mean = '1;
    end else begin
      zone_mean = scaled[7:4];
    end
  endfunction

endpackage

// File: rtl/led_zone_acc.sv
// One colour channel: four zone accumulators for the active band plus mean logic.
// Latency: accumulate on the accepting edge; band_mean is combinational from the sums.
// Backpressure: none; add/clr are applied every cycle they are asserted.
// Rounding of the mean is enabled when LED_ZONE_ROUND_EN is defined.
module led_zone_acc
  import led_pkg::*;
#(
  parameter int ZONE_W_LOG2 = 4,
  parameter int ZONE_H_LOG2 = 4
) (
  input  logic             clk_slow,
  input  logic             rstn,
  input  logic             clr,
  input  logic             add,
  input  logic [1:0]       col,
  input  logic [PIX_W-1:0] pix,
  output band_mean_t       band_mean
);

  localparam int SHIFT = ZONE_W_LOG2 + ZONE_H_LOG2;
  localparam int ACC_W = PIX_W + SHIFT;
  localparam logic [ACC_W-1:0] ACC_ZERO = '0;

`ifdef LED_ZONE_ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  // A zone holds at most 2^SHIFT pixels of 8 bits, so ACC_W bits never overflow.
  logic [ACC_W-1:0] acc [ZONE_COLS];

  // Per-zone sums; a clear and an add in the same cycle leave just the new pixel.
  always_ff @(posedge clk_slow) begin
    if (!rstn) begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        acc[c] <= ACC_ZERO;
      end
    end else begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        if (add && (col == 2'(c))) begin
          acc[c] <= (clr ? ACC_ZERO : acc[c]) + ACC_W'(pix);
        end else if (clr) begin
          acc[c] <= ACC_ZERO;
        end
      end
    end
  end

  // Mean of each zone of the band, ready for the band write-back cycle.
  always_comb begin
    for (int c = 0; c < ZONE_COLS; c++) begin
      band_mean[c] = zone_mean(32'(acc[c]), SHIFT, ROUND);
    end
  end

endmodule

// File: rtl/led_zone_mean.sv
// Per-zone RGB means over a 4x4 zone grid; publishes a full mean set and pulses start.
// Latency: last pixel on edge N -> band 3 in working bank at N+1, outputs and start at N+2.
// Backpressure: none; pixels that cannot be accepted are dropped. Option: LED_ZONE_ROUND_EN.
module led_zone_mean
  import led_pkg::*;
#(
  parameter int ZONE_W_LOG2 = 4,
  parameter int ZONE_H_LOG2 = 4
) (
  input  logic             clk_slow,
  input  logic             rstn,
  input  logic             en,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  output mean_arr_t        MeanR,
  output mean_arr_t        MeanG,
  output mean_arr_t        MeanB,
  output logic             start,
  output logic             frame_err
);

  localparam int XW = ZONE_W_LOG2 + 2;
  localparam int YW = ZONE_H_LOG2 + 2;
  localparam logic [XW-1:0] X_LAST    = '1;
  localparam logic [YW-1:0] LINE_MASK = YW'((1 << ZONE_H_LOG2) - 1);

  zm_state_e     state;
  zm_state_e     state_nxt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [1:0]    band_wr;
  logic [1:0]    col;
  logic          accept;
  logic          restart;
  logic          acc_clr;
  logic          bank_wr;
  logic          bank_clr;
  logic          publish;
  logic          frame_abort;
  logic          band_last;

  band_mean_t r_mean;
  band_mean_t g_mean;
  band_mean_t b_mean;
  mean_arr_t  bank_r;
  mean_arr_t  bank_g;
  mean_arr_t  bank_b;

  // State register.
  always_ff @(posedge clk_slow) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus per-cycle control: which pixel is taken, at what position,
  // and whether accumulators / working bank are cleared or written.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    restart     = 1'b0;
    acc_clr     = 1'b0;
    bank_wr     = 1'b0;
    bank_clr    = 1'b0;
    publish     = 1'b0;
    frame_abort = 1'b0;
    pos_x       = x_cnt;
    pos_y       = y_cnt;

    case (state)
      ST_IDLE: begin
        acc_clr = 1'b1;
        if (pix_valid && pix_sof) begin
          accept    = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        if (pix_valid) begin
          accept = 1'b1;
          if (pix_sof) begin
            // Early sof: abandon this frame, the sof pixel opens the next one.
            restart     = 1'b1;
            acc_clr     = 1'b1;
            bank_clr    = 1'b1;
            frame_abort = 1'b1;
          end
        end
      end
      ST_BAND: begin
        acc_clr = 1'b1;
        bank_wr = 1'b1;
        // Next band keeps streaming; a sof here, or anything after band 3, is dropped.
        if (pix_valid && !pix_sof && (band_wr != 2'd3)) begin
          accept = 1'b1;
        end
        state_nxt = (band_wr == 2'd3) ? ST_PUB : ST_ACC;
      end
      ST_PUB: begin
        acc_clr   = 1'b1;
        publish   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (restart) begin
      pos_x = '0;
      pos_y = '0;
    end

    band_last = accept && (pos_x == X_LAST) && ((pos_y & LINE_MASK) == LINE_MASK);
    if (band_last) begin
      state_nxt = ST_BAND;
    end

    // Disabled: drop everything in flight; published outputs are untouched.
    if (!en) begin
      state_nxt   = ST_IDLE;
      accept      = 1'b0;
      restart     = 1'b0;
      band_last   = 1'b0;
      acc_clr     = 1'b1;
      bank_wr     = 1'b0;
      bank_clr    = 1'b1;
      publish     = 1'b0;
      frame_abort = 1'b0;
    end

    col = pos_x[XW-1 -: 2];
  end

  // Raster position of the next expected pixel, and which band just finished.
  always_ff @(posedge clk_slow) begin
    if (!rstn || !en) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      band_wr <= '0;
    end else begin
      if (accept) begin
        if (pos_x == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= pos_y + YW'(1);
        end else begin
          x_cnt <= pos_x + XW'(1);
          y_cnt <= pos_y;
        end
      end
      if (band_last) begin
        band_wr <= pos_y[YW-1 -: 2];
      end
    end
  end

  led_zone_acc #(
    .ZONE_W_LOG2(ZONE_W_LOG2),
    .ZONE_H_LOG2(ZONE_H_LOG2)
  ) u_acc_r (
    .clk_slow (clk_slow),
    .rstn     (rstn),
    .clr      (acc_clr),
    .add      (accept),
    .col      (col),
    .pix      (pix_r),
    .band_mean(r_mean)
  );

  led_zone_acc #(
    .ZONE_W_LOG2(ZONE_W_LOG2),
    .ZONE_H_LOG2(ZONE_H_LOG2)
  ) u_acc_g (
    .clk_slow (clk_slow),
    .rstn     (rstn),
    .clr      (acc_clr),
    .add      (accept),
    .col      (col),
    .pix      (pix_g),
    .band_mean(g_mean)
  );

  led_zone_acc #(
    .ZONE_W_LOG2(ZONE_W_LOG2),
    .ZONE_H_LOG2(ZONE_H_LOG2)
  ) u_acc_b (
    .clk_slow (clk_slow),
    .rstn     (rstn),
    .clr      (acc_clr),
    .add      (accept),
    .col      (col),
    .pix      (pix_b),
    .band_mean(b_mean)
  );

  // Working bank: collects band results until the whole frame is known.
  always_ff @(posedge clk_slow) begin
    if (!rstn || bank_clr) begin
      for (int z = 0; z < ZONE_NUM; z++) begin
        bank_r[z] <= '0;
        bank_g[z] <= '0;
        bank_b[z] <= '0;
      end
    end else if (bank_wr) begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        bank_r[{band_wr, 2'(c)}] <= r_mean[c];
        bank_g[{band_wr, 2'(c)}] <= g_mean[c];
        bank_b[{band_wr, 2'(c)}] <= b_mean[c];
      end
    end
  end

  // Published set changes atomically on the start edge; pulses are single-cycle.
  always_ff @(posedge clk_slow) begin
    if (!rstn) begin
      for (int z = 0; z < ZONE_NUM; z++) begin
        MeanR[z] <= '0;
        MeanG[z] <= '0;
        MeanB[z] <= '0;
      end
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start     <= publish;
      frame_err <= frame_abort;
      if (publish) begin
        MeanR <= bank_r;
        MeanG <= bank_g;
        MeanB <= bank_b;
      end
    end
  end

endmodule

// File: tb/tb_led_zone_mean.sv
// Bench for led_zone_mean: raster frames with fixed and random pixels, checked against
// zone sums kept by the bench. Expected means follow LED_ZONE_ROUND_EN when defined.
module tb_led_zone_mean;
  import led_pkg::*;

  localparam int ZWL  = 4;
  localparam int ZHL  = 4;
  localparam int ZW   = 1 << ZWL;
  localparam int ZH   = 1 << ZHL;
  localparam int FW   = 4 * ZW;
  localparam int FH   = 4 * ZH;
  localparam int NPIX = FW * FH;

  logic       clk_slow = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_r = 8'd0;
  logic [7:0] pix_g = 8'd0;
  logic [7:0] pix_b = 8'd0;
  mean_arr_t  MeanR;
  mean_arr_t  MeanG;
  mean_arr_t  MeanB;
  logic       start;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int cval = 0;
  int zsum [3][ZONE_NUM];
  int pub  [3][ZONE_NUM];

  always #5 clk_slow = ~clk_slow;

  led_zone_mean #(
    .ZONE_W_LOG2(ZWL),
    .ZONE_H_LOG2(ZHL)
  ) dut (
    .clk_slow (clk_slow),
    .rstn     (rstn),
    .en       (en),
    .pix_valid(pix_valid),
    .pix_sof  (pix_sof),
    .pix_r    (pix_r),
    .pix_g    (pix_g),
    .pix_b    (pix_b),
    .MeanR    (MeanR),
    .MeanG    (MeanG),
    .MeanB    (MeanB),
    .start    (start),
    .frame_err(frame_err)
  );

  always @(posedge clk_slow) begin
    if (start === 1'b1) start_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  // Zone mean: average over the zone area, top nibble of the 8-bit average.
  function automatic int exp_mean(input int sum);
    int m;
`ifdef LED_ZONE_ROUND_EN
    m = (sum + ZW * ZH * 8) / (ZW * ZH * 16);
    if (m > 15) m = 15;
`else
    m = sum / (ZW * ZH * 16);
`endif
    return m;
  endfunction

  function automatic logic [7:0] pval(input int mode, input int ch, input int z);
    case (mode)
      0:       return (ch == 0) ? 8'h80 : (ch == 1) ? 8'h40 : 8'hFF;
      1:       return (ch == 0) ? 8'(16 * z) : (ch == 1) ? 8'(240 - 16 * z) : 8'h00;
      2:       return 8'(cval);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [3:0] get_mean(input int ch, input int z);
    case (ch)
      0:       return MeanR[z];
      1:       return MeanG[z];
      default: return MeanB[z];
    endcase
  endfunction

  task automatic idle_inputs();
    pix_valid = 1'b0;
    pix_sof   = 1'($urandom_range(0, 1));
    pix_r     = 8'($urandom_range(0, 255));
    pix_g     = 8'($urandom_range(0, 255));
    pix_b     = 8'($urandom_range(0, 255));
  endtask

  task automatic compare_means(input string tag);
    logic [3:0] got;
    for (int ch = 0; ch < 3; ch++) begin
      for (int z = 0; z < ZONE_NUM; z++) begin
        got = get_mean(ch, z);
        tests++;
        if (got !== 4'(pub[ch][z])) begin
          fails++;
          $display("FAIL %s ch%0d zone%0d: got %0d expected %0d", tag, ch, z, got, pub[ch][z]);
        end
      end
    end
  endtask

  // Drive the first npix pixels of a raster frame; gap 0 none, 1 alternate, 2 random.
  task automatic send_frame(input int mode, input int npix, input int gap, input bit chk_err);
    int x, y, z, ng;
    logic [7:0] v [3];
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < ZONE_NUM; k++) zsum[c][k] = 0;
    for (int p = 0; p < npix; p++) begin
      x = p % FW;
      y = p / FW;
      z = (y / ZH) * 4 + x / ZW;
      ng = (gap == 1 && p > 0) ? 1 : (gap == 2) ? int'($urandom_range(0, 1)) : 0;
      repeat (ng) begin
        @(negedge clk_slow);
        idle_inputs();
      end
      for (int c = 0; c < 3; c++) begin
        v[c] = pval(mode, c, z);
        zsum[c][z] += int'(v[c]);
      end
      @(negedge clk_slow);
      if (chk_err && p == 1) begin
        tests++;
        if (frame_err !== 1'b1) begin
          fails++;
          $display("FAIL frame_err pulse: got %b expected 1", frame_err);
        end
      end
      if (chk_err && p == 2) begin
        tests++;
        if (frame_err !== 1'b0) begin
          fails++;
          $display("FAIL frame_err width: got %b expected 0", frame_err);
        end
      end
      pix_valid = 1'b1;
      pix_sof   = (p == 0);
      pix_r     = v[0];
      pix_g     = v[1];
      pix_b     = v[2];
    end
  endtask

  // After the last pixel: start low at N, N+1, high at N+2, low at N+3; outputs swap at N+2.
  task automatic check_publish(input string tag);
    logic [3:0] s;
    int s0;
    s0 = start_cnt;
    s = 4'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_slow);
      if (k == 0) idle_inputs();
      s[k] = start;
      if (k == 1) compare_means({tag, " pre-start hold"});
      if (k == 2) begin
        for (int c = 0; c < 3; c++)
          for (int z = 0; z < ZONE_NUM; z++) pub[c][z] = exp_mean(zsum[c][z]);
        compare_means(tag);
      end
    end
    tests++;
    if (s !== 4'b0100) begin
      fails++;
      $display("FAIL %s start timing: got %b expected 0100 (bit k = edge N+k)", tag, s);
    end
    @(negedge clk_slow);
    tests++;
    if (start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL %s start count: got %0d expected 1", tag, start_cnt - s0);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk_slow);
    for (int c = 0; c < 3; c++)
      for (int z = 0; z < ZONE_NUM; z++) pub[c][z] = 0;
    tests++;
    if (start !== 1'b0) begin
      fails++;
      $display("FAIL reset start: got %b expected 0", start);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset frame_err: got %b expected 0", frame_err);
    end
    compare_means("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk_slow);
  endtask

  task automatic test_uniform();
    send_frame(0, NPIX, 0, 1'b0);
    check_publish("uniform");
  endtask

  task automatic test_per_zone();
    send_frame(1, NPIX, 0, 1'b0);
    check_publish("per_zone");
  endtask

  task automatic test_rounding();
    cval = 8'h78;
    send_frame(2, NPIX, 0, 1'b0);
    check_publish("const_78");
    cval = 8'hFC;
    send_frame(2, NPIX, 0, 1'b0);
    check_publish("const_FC");
  endtask

  task automatic test_premature_sof();
    int e0, s0;
    e0 = err_cnt;
    s0 = start_cnt;
    send_frame(3, 1000, 0, 1'b0);
    cval = 8'h20;
    send_frame(2, NPIX, 0, 1'b1);
    check_publish("after_abort");
    tests++;
    if (err_cnt - e0 != 1) begin
      fails++;
      $display("FAIL abort frame_err count: got %0d expected 1", err_cnt - e0);
    end
    tests++;
    if (start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL abort start count: got %0d expected 1", start_cnt - s0);
    end
  endtask

  task automatic test_valid_gaps();
    send_frame(0, NPIX, 1, 1'b0);
    check_publish("alternate_gaps");
    send_frame(3, NPIX, 2, 1'b0);
    check_publish("random_gaps");
  endtask

  task automatic test_en_low();
    int s0;
    s0 = start_cnt;
    send_frame(3, 2000, 0, 1'b0);
    @(negedge clk_slow);
    en = 1'b0;
    repeat (3) @(negedge clk_slow);
    idle_inputs();
    en = 1'b1;
    repeat (6) @(negedge clk_slow);
    tests++;
    if (start_cnt != s0) begin
      fails++;
      $display("FAIL en_low start count: got %0d expected 0", start_cnt - s0);
    end
    compare_means("en_low hold");
    send_frame(1, NPIX, 0, 1'b0);
    check_publish("after_en_low");
  endtask

  task automatic test_rstn_mid();
    send_frame(3, 2000, 0, 1'b0);
    @(negedge clk_slow);
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_slow);
    for (int c = 0; c < 3; c++)
      for (int z = 0; z < ZONE_NUM; z++) pub[c][z] = 0;
    tests++;
    if (start !== 1'b0) begin
      fails++;
      $display("FAIL rstn_mid start: got %b expected 0", start);
    end
    compare_means("rstn_mid");
    rstn = 1'b1;
    @(negedge clk_slow);
    send_frame(3, NPIX, 0, 1'b0);
    check_publish("after_rstn");
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_slow);
      pix_valid = 1'b1;
      pix_sof   = 1'b0;
      pix_r     = 8'($urandom_range(0, 255));
      pix_g     = 8'($urandom_range(0, 255));
      pix_b     = 8'($urandom_range(0, 255));
    end
    send_frame(3, NPIX, 0, 1'b0);
    check_publish("after_stray");
    tests++;
    if (err_cnt != e0) begin
      fails++;
      $display("FAIL stray pixels frame_err: got %0d expected 0", err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_per_zone();
    test_rounding();
    test_premature_sof();
    test_valid_gaps();
    test_en_low();
    test_rstn_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_zone_mean.md
# led_zone_mean

Computes per-zone colour means for the LED controller. Accepts one RGB888 pixel per cycle from the video front end, partitions the active frame into a 4×4 grid of 16 zones, and accumulates each zone's R/G/B sums. At end of frame it publishes 16 × 4-bit means per channel on MeanR/MeanG/MeanB and pulses `start` for one cycle. These outputs drive `led_ctrl_top` directly in the `clk_slow` domain.

## Interface
- `ZONE_W_LOG2`, default 4: log2 of zone width in pixels; frame width = 4 << ZONE_W_LOG2.
- `ZONE_H_LOG2`, default 4: log2 of zone height in lines; frame height = 4 << ZONE_H_LOG2.
- `clk_slow`  in  1  block clock; only clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `en`  in  1  level enable; low drops the current frame and ignores pixels.
- `pix_valid`  in  1  pixel qualifier.
- `pix_sof`  in  1  first pixel of frame; meaningful only with `pix_valid`.
- `pix_r`, `pix_g`, `pix_b`  in  8 each  pixel colour.
- `MeanR`, `MeanG`, `MeanB`  out  [3:0] × [15:0] unpacked  zone means; zone = band*4 + column, with column 0 leftmost and band 0 top.
- `start`  out  1  one-cycle pulse when a new mean set is valid.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted by a premature `pix_sof`.

## Operation
- States:
  - IDLE: wait for `pix_valid & pix_sof`.
  - ACC: accumulate pixels.
  - BAND: one-cycle write of band results.
  - PUB: one-cycle publish.
- Pixel tracking: x/y counters advance on each accepted pixel (`pix_valid` in ACC, or the sof pixel in IDLE). Column = x[MSB:MSB-1]; band = y[MSB:MSB-1].
- Accumulators: only the active band is held, so 4 zones × 3 channels = 12 accumulators.
  - Width: 8 + ZONE_W_LOG2 + ZONE_H_LOG2 bits (16 at default).
  - No overflow is possible.
- Mean: sum >> (ZONE_W_LOG2 + ZONE_H_LOG2), then bits [7:4] of the 8-bit result.
- Band end (last pixel of the band's last line): the next cycle (BAND) writes the 4 zone means into the working bank and clears the accumulators.
- Frame end: after band 3 is written, PUB copies the working bank to the outputs, asserts `start`, and returns to IDLE.
- Pixels that arrive after frame end without `pix_sof` are ignored.
- Boundary conditions:
  - `pix_sof` in ACC before frame end: pulse `frame_err`, clear accumulators and working bank, and treat that pixel as (0,0) of a new frame.
  - `pix_sof` in BAND/PUB: the current frame completes normally and the sof pixel is dropped.
  - `en` low: return to IDLE, clear accumulators; outputs hold their last values; no `start`.
  - `pix_valid` gaps: counters and accumulators hold.

## Timing
- Reset values: MeanR/G/B all 0, `start` = 0, `frame_err` = 0, state IDLE, counters 0.
- Last pixel of the frame accepted on edge N:
  - edge N+1: working bank band 3 written;
  - edge N+2: outputs update and `start` = 1;
  - edge N+3: `start` = 0.
- MeanR/G/B change only on the `start` edge; a set is never partially updated.
- `frame_err` is high for the cycle after the offending sof is accepted.
- Pixels arriving during BAND are accepted; the accumulator clear and the new pixel's add merge in that cycle.

## Configuration
- `LED_ZONE_ROUND_EN`:
  - Defined: add 1 << (ZONE_W_LOG2 + ZONE_H_LOG2 + 3) to the sum before truncation, saturating the result at 4'hF.
  - Undefined: plain truncation.

## Structure
- Package `led_pkg` holds:
  - ZONE_NUM = 16, MEAN_W = 4, PIX_W = 8;
  - typedef `mean_arr_t` (logic [3:0] × [15:0]);
  - state enum `zm_state_e`.
- Sub-module `led_zone_acc`: one colour channel's 4 band accumulators plus mean/round logic; instantiated 3× (R, G, B).

## Test plan
- Uniform frame, R = 0x80, G = 0x40, B = 0xFF → all MeanR = 8, MeanG = 4, MeanB = F; a single `start` at N+2.
- Per-zone fill with R = 0x10*zone, G = 0xF0 − 0x10*zone, B = 0x00 → MeanR[i] = i, MeanG[i] = F − i, MeanB[i] = 0.
- All pixels 0x78:
  - without the macro → all means 7;
  - with `LED_ZONE_ROUND_EN` → 8;
  - all 0xFC with the macro → F (saturated).
- Premature `pix_sof` after 1000 pixels → `frame_err` pulse and no `start`; the following full frame of 0x20 → all means 2 and one `start`.
- `pix_valid` toggling every other cycle with the uniform frame → same means as the uniform-frame case.
- Disruption mid-frame:
  - `en` low mid-frame → no `start`, outputs hold previous values;
  - `rstn` low mid-frame → outputs 0, `start` 0;
  - in both cases the next full frame is published correctly.
